// File: rtl/alu_trace_recorder.sv
// Packs live ALU transactions into 104-bit vector records and streams them out
// of a first-word-fall-through FIFO over a valid/ready port.
module alu_trace_recorder #(
  parameter int N           = 32,
  parameter int DEPTH       = 16,
  parameter int MAX_RECORDS = 10000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_in_valid,
  input  logic [3:0]       i_in_op,
  input  logic [N-1:0]     i_in_a,
  input  logic [N-1:0]     i_in_b,
  input  logic [N-1:0]     i_in_result,
  input  logic             i_in_zero,
  output logic             o_rec_valid,
  input  logic             i_rec_ready,
  output logic [3*N+7:0]   o_rec_data,
  output logic [31:0]      o_rec_count,
  output logic [15:0]      o_drop_count,
  output logic             o_overflow,
  output logic             o_busy,
  output logic             o_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int W  = 3*N + 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_stateNext;
  logic [PW-1:0]  r_wrPtr;
  logic [PW-1:0]  r_rdPtr;
  logic [W-1:0]   r_mem [DEPTH];
  logic [31:0]    r_recCount;
  logic [15:0]    r_dropCount;
  logic           r_overflow;

  logic           w_empty;
  logic           w_full;
  logic           w_push;
  logic           w_pop;
  logic           w_accept;
  logic           w_drop;
  logic           w_lastRecord;
  logic [W-1:0]   w_record;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign w_empty      = (r_wrPtr == r_rdPtr);
  assign w_full       = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_push       = (r_state == RUN) && i_in_valid;
  assign w_pop        = !w_empty && i_rec_ready;
  assign w_accept     = w_push && (!w_full || w_pop);
  assign w_drop       = w_push && w_full && !w_pop;
  assign w_lastRecord = w_accept && (r_recCount == 32'(MAX_RECORDS - 1));
  assign w_record     = {i_in_op, i_in_a, i_in_b, i_in_result, 3'b000, i_in_zero};

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (i_start) w_stateNext = RUN;
      RUN:     if (i_stop || w_lastRecord) w_stateNext = DONE;
      DONE:    w_stateNext = DONE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_recCount  <= '0;
      r_dropCount <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (w_accept) begin
        r_wrPtr    <= r_wrPtr + PW'(1);
        r_recCount <= r_recCount + 32'd1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_dropCount != 16'hFFFF) begin
          r_dropCount <= r_dropCount + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept && !i_reset) begin
      r_mem[r_wrPtr[AW-1:0]] <= w_record;
    end
  end

  assign o_rec_valid  = !w_empty;
  assign o_rec_data   = w_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];
  assign o_rec_count  = r_recCount;
  assign o_drop_count = r_dropCount;
  assign o_overflow   = r_overflow;
  assign o_busy       = (r_state == RUN);
  assign o_done       = (r_state == DONE) && w_empty;

endmodule

// File: tb/tb_alu_trace_recorder.sv
// Drives two recorder instances (default sizing and a tiny FIFO/record limit) with
// directed and random traffic, comparing every output against a queue-based model.
module tb_alu_trace_recorder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        inValid = 1'b0;
  logic [3:0]  inOp = '0;
  logic [31:0] inA = '0;
  logic [31:0] inB = '0;
  logic [31:0] inResult = '0;
  logic        inZero = 1'b0;
  logic        recReady = 1'b0;

  logic          recValidObs [2];
  logic [103:0]  recDataObs  [2];
  logic [31:0]   recCountObs [2];
  logic [15:0]   dropCountObs[2];
  logic          overflowObs [2];
  logic          busyObs     [2];
  logic          doneObs     [2];

  int numVectors = 0;
  int numMiscompares = 0;

  // Reference model state, one slot per instance.
  int           depthOf[2] = '{16, 4};
  int           maxOf[2]   = '{10000, 4};
  logic [103:0] mq[2][$];
  int           mCount[2];
  int           mDrop[2];
  bit           mOvf[2];
  bit           mRun[2];
  bit           mFinished[2];

  always #5 clock = ~clock;

  alu_trace_recorder #(.N(32), .DEPTH(16), .MAX_RECORDS(10000)) u_dut (
    .i_clk(clock), .i_reset(reset), .i_start(start), .i_stop(stop),
    .i_in_valid(inValid), .i_in_op(inOp), .i_in_a(inA), .i_in_b(inB),
    .i_in_result(inResult), .i_in_zero(inZero),
    .o_rec_valid(recValidObs[0]), .i_rec_ready(recReady), .o_rec_data(recDataObs[0]),
    .o_rec_count(recCountObs[0]), .o_drop_count(dropCountObs[0]),
    .o_overflow(overflowObs[0]), .o_busy(busyObs[0]), .o_done(doneObs[0])
  );

  alu_trace_recorder #(.N(32), .DEPTH(4), .MAX_RECORDS(4)) u_dutSmall (
    .i_clk(clock), .i_reset(reset), .i_start(start), .i_stop(stop),
    .i_in_valid(inValid), .i_in_op(inOp), .i_in_a(inA), .i_in_b(inB),
    .i_in_result(inResult), .i_in_zero(inZero),
    .o_rec_valid(recValidObs[1]), .i_rec_ready(recReady), .o_rec_data(recDataObs[1]),
    .o_rec_count(recCountObs[1]), .o_drop_count(dropCountObs[1]),
    .o_overflow(overflowObs[1]), .o_busy(busyObs[1]), .o_done(doneObs[1])
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    numVectors++;
    if (observed !== expected) begin
      numMiscompares++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mCount[k] = 0;
      mDrop[k] = 0;
      mOvf[k] = 0;
      mRun[k] = 0;
      mFinished[k] = 0;
    end
  endtask

  // One clock edge of the recorder's documented behaviour, seen from outside.
  task automatic modelStep();
    for (int k = 0; k < 2; k++) begin
      bit pop;
      bit accepted;
      pop = (mq[k].size() > 0) && recReady;
      accepted = 0;
      if (mRun[k] && inValid) begin
        if (mq[k].size() < depthOf[k] || pop) begin
          accepted = 1;
        end else begin
          mOvf[k] = 1;
          if (mDrop[k] != 16'hFFFF) mDrop[k]++;
        end
      end
      if (pop) void'(mq[k].pop_front());
      if (accepted) begin
        mq[k].push_back({inOp, inA, inB, inResult, 3'b000, inZero});
        mCount[k]++;
      end
      if (!mRun[k] && !mFinished[k]) begin
        if (start) mRun[k] = 1;
      end else if (mRun[k] && (stop || (accepted && mCount[k] == maxOf[k]))) begin
        mRun[k] = 0;
        mFinished[k] = 1;
      end
    end
  endtask

  task automatic checkAll();
    for (int k = 0; k < 2; k++) begin
      logic [103:0] expData;
      expData = (mq[k].size() > 0) ? mq[k][0] : '0;
      checkOutput($sformatf("recValid[%0d]", k), 128'(recValidObs[k]), 128'(mq[k].size() > 0));
      checkOutput($sformatf("recData[%0d]", k), 128'(recDataObs[k]), 128'(expData));
      checkOutput($sformatf("recCount[%0d]", k), 128'(recCountObs[k]), 128'(mCount[k]));
      checkOutput($sformatf("dropCount[%0d]", k), 128'(dropCountObs[k]), 128'(mDrop[k]));
      checkOutput($sformatf("overflow[%0d]", k), 128'(overflowObs[k]), 128'(mOvf[k]));
      checkOutput($sformatf("busy[%0d]", k), 128'(busyObs[k]), 128'(mRun[k]));
      checkOutput($sformatf("done[%0d]", k), 128'(doneObs[k]), 128'(mFinished[k] && mq[k].size() == 0));
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clock);
    modelReset();
    #1 checkAll();
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic v, input logic rdy,
                               input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res);
    start = st;
    stop = sp;
    inValid = v;
    recReady = rdy;
    inOp = op;
    inA = a;
    inB = b;
    inResult = res;
    inZero = (res == 32'd0);
    @(posedge clock);
    modelStep();
    #1 checkAll();
  endtask

  task automatic randStim(input int pStart, input int pStop, input int pValid, input int pReady);
    logic [31:0] res;
    res = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    applyStimulus($urandom_range(0, 99) < pStart, $urandom_range(0, 99) < pStop,
                  $urandom_range(0, 99) < pValid, $urandom_range(0, 99) < pReady,
                  4'($urandom_range(0, 15)), $urandom, $urandom, res);
  endtask

  task automatic idleCycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, rdy, 4'h0, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    modelReset();
    doReset();
    doReset();

    applyStimulus(1, 0, 0, 0, 4'h0, 32'd0, 32'd0, 32'd0);
    applyStimulus(0, 0, 1, 0, 4'h0, 32'h00000005, 32'h00000003, 32'h00000008);
    checkOutput("firstRecord", 128'(recDataObs[0]), 128'(104'h0_00000005_00000003_00000008_0));
    checkOutput("firstCount", 128'(recCountObs[0]), 128'd1);

    idleCycles(1, 1);
    applyStimulus(0, 0, 1, 0, 4'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0);
    checkOutput("zeroFlags", 128'(recDataObs[0][3:0]), 128'h1);
    idleCycles(1, 1);
    checkOutput("popEmpty", 128'(recValidObs[0]), 128'd0);

    // Overfill the large FIFO by one, then push and pop together while full.
    for (int i = 0; i < 17; i++) randStim(0, 0, 100, 0);
    checkOutput("fullDrops", 128'(dropCountObs[0]), 128'd1);
    randStim(0, 0, 100, 100);
    idleCycles(20, 1);

    for (int i = 0; i < 400; i++) randStim(0, 0, 70, 50);
    applyStimulus(0, 1, 1, 0, 4'h7, 32'h1234, 32'h5678, 32'h68AC);
    idleCycles(20, 1);
    checkOutput("doneAfterDrain", 128'(doneObs[0]), 128'd1);

    doReset();
    applyStimulus(1, 1, 0, 0, 4'h0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) randStim(0, 0, 100, 0);
    doReset();
    for (int i = 0; i < 5; i++) randStim(0, 0, 100, 50);
    checkOutput("ignoredInIdle", 128'(recCountObs[0]), 128'd0);

    applyStimulus(1, 0, 0, 0, 4'h0, 32'd0, 32'd0, 32'd0);
    for (int i = 0; i < 600; i++) randStim(5, 1, 60, 60);
    idleCycles(20, 1);

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
